// File: rtl/seed_pkg.sv
// seed_pkg: shared block width, FSM encoding and word-count helper for the SEED stream front end
package seed_pkg;
    localparam int BLOCK_W = 128;
    typedef enum logic [2:0] {IDLE, FILL, START, WAIT, SEND} state_t;
    function automatic int words(input int data_w);
        return BLOCK_W / data_w;
    endfunction
endpackage

// File: rtl/seed_word_pack.sv
// seed_word_pack: packs DATA_W words MSB-first into a 128-bit block and flags its first/last word
module seed_word_pack
    import seed_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DATA_W-1:0]  data,
    output logic [BLOCK_W-1:0] blk,
    output logic               first,
    output logic               last
);
    localparam int WORDS = words(DATA_W);
    localparam int CW = $clog2(WORDS);
    logic [CW-1:0] cnt;
    assign first = cnt == '0;
    assign last = load && cnt == CW'(WORDS - 1);
    // shift each word in at the bottom so the first word ends up in the top bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk <= '0;
            cnt <= '0;
        end else if (load) begin
            blk <= {blk[BLOCK_W-DATA_W-1:0], data};
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seed_stream_ctrl.sv
// seed_stream_ctrl: streams key/text words into an external SEED core and streams its result back out
module seed_stream_ctrl
    import seed_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_is_key,
    input  logic               enc_dec,
    output logic               core_start,
    output logic               core_enc_dec,
    output logic [BLOCK_W-1:0] core_text,
    output logic [BLOCK_W-1:0] core_key,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               key_loaded,
    output logic               err,
    output logic [CNT_W-1:0]   blk_cnt
);
    localparam int WORDS = words(DATA_W);
    localparam int OW = $clog2(WORDS);
    state_t state, state_nx;
    logic [BLOCK_W-1:0] res;
    logic [OW-1:0] out_cnt;
    logic key_acc, txt_acc, key_first, key_done, txt_done, out_hs, unused_txt_first;
    assign in_ready = !reset && (state == IDLE || state == FILL);
    assign core_start = state == START;
    assign out_valid = state == SEND;
    assign out_last = out_valid && out_cnt == OW'(WORDS - 1);
    assign out_data = res[BLOCK_W-1 -: DATA_W];
    assign key_acc = in_valid && in_ready && in_is_key;
    assign txt_acc = in_valid && in_ready && !in_is_key;
    assign out_hs = out_valid && out_ready;

    seed_word_pack #(.DATA_W(DATA_W)) u_key_pack (
        .clk(clk), .reset(reset), .load(key_acc), .data(in_data),
        .blk(core_key), .first(key_first), .last(key_done)
    );

    seed_word_pack #(.DATA_W(DATA_W)) u_txt_pack (
        .clk(clk), .reset(reset), .load(txt_acc), .data(in_data),
        .blk(core_text), .first(unused_txt_first), .last(txt_done)
    );

    // control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // next state: a text block without a held key is dropped back to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? FILL : IDLE;
            FILL:    state_nx = txt_done ? (key_loaded ? START : IDLE) : FILL;
            START:   state_nx = WAIT;
            WAIT:    state_nx = core_done ? SEND : WAIT;
            SEND:    state_nx = out_hs && out_last ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end

    // key status, mode sampling, error pulse, result capture/unload and block count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_loaded   <= 1'b0;
            err          <= 1'b0;
            core_enc_dec <= 1'b0;
            res          <= '0;
            out_cnt      <= '0;
            blk_cnt      <= '0;
        end else begin
            err <= txt_done && !key_loaded;
            if (key_acc && key_first) key_loaded <= 1'b0;
            if (key_done) key_loaded <= 1'b1;
            if (txt_done && key_loaded) core_enc_dec <= enc_dec;
            if (state == WAIT && core_done) res <= core_result;
            else if (out_hs) res <= {res[BLOCK_W-DATA_W-1:0], {DATA_W{1'b0}}};
            if (out_hs) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
            if (out_hs && out_last) blk_cnt <= blk_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_seed_stream_ctrl.sv
// tb_seed_stream_ctrl: drives an 8-bit/CNT_W=2 and a 32-bit instance against a behavioural core and stream model
module tb_seed_stream_ctrl;
    typedef struct {
        logic         s;
        logic         ld;
        logic [127:0] key;
        logic [127:0] text;
        logic         mode;
        logic         exp_err;
        logic [127:0] exp_res;
        logic [15:0]  exp_cnt;
        logic         stall;
    } vec_t;

    localparam logic [127:0] PT0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KAT = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
    localparam logic [127:0] K3  = 128'h4706480851E61BE85D74BFB3FD956185;
    localparam logic [127:0] KB  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    logic clk = 0, reset = 1, sel = 0;
    logic in_valid = 0, in_is_key = 0, enc_dec = 0, out_ready = 0, core_done = 0;
    logic [63:0] in_data = '0;
    logic [127:0] core_result = '0;
    int n_tests = 0, n_fail = 0;

    logic ir_a, cs_a, ced_a, ov_a, ol_a, kl_a, er_a, ir_b, cs_b, ced_b, ov_b, ol_b, kl_b, er_b;
    logic [127:0] ct_a, ck_a, ct_b, ck_b;
    logic [7:0] od_a;
    logic [31:0] od_b;
    logic [1:0] bc_a;
    logic [15:0] bc_b;

    logic in_ready, core_start, core_enc_dec, out_valid, out_last, key_loaded, err;
    logic [127:0] core_text, core_key;
    logic [63:0] out_data;
    logic [15:0] blk_cnt;
    assign in_ready = sel ? ir_b : ir_a;
    assign core_start = sel ? cs_b : cs_a;
    assign core_enc_dec = sel ? ced_b : ced_a;
    assign out_valid = sel ? ov_b : ov_a;
    assign out_last = sel ? ol_b : ol_a;
    assign key_loaded = sel ? kl_b : kl_a;
    assign err = sel ? er_b : er_a;
    assign core_text = sel ? ct_b : ct_a;
    assign core_key = sel ? ck_b : ck_a;
    assign out_data = sel ? 64'(od_b) : 64'(od_a);
    assign blk_cnt = sel ? bc_b : 16'(bc_a);

    seed_stream_ctrl #(.DATA_W(8), .CNT_W(2)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(ir_a), .in_data(in_data[7:0]),
        .in_is_key(in_is_key), .enc_dec(enc_dec), .core_start(cs_a), .core_enc_dec(ced_a),
        .core_text(ct_a), .core_key(ck_a), .core_done(core_done & ~sel), .core_result(core_result),
        .out_valid(ov_a), .out_ready(out_ready & ~sel), .out_data(od_a), .out_last(ol_a),
        .key_loaded(kl_a), .err(er_a), .blk_cnt(bc_a)
    );

    seed_stream_ctrl #(.DATA_W(32), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(ir_b), .in_data(in_data[31:0]),
        .in_is_key(in_is_key), .enc_dec(enc_dec), .core_start(cs_b), .core_enc_dec(ced_b),
        .core_text(ct_b), .core_key(ck_b), .core_done(core_done & sel), .core_result(core_result),
        .out_valid(ov_b), .out_ready(out_ready & sel), .out_data(od_b), .out_last(ol_b),
        .key_loaded(kl_b), .err(er_b), .blk_cnt(bc_b)
    );

    always #5 clk = ~clk;

    // stand-in cipher: the published all-zero-key vector, otherwise a keyed rotate/xor
    function automatic logic [127:0] ref_core(input logic [127:0] t, input logic [127:0] k, input logic m);
        if (k == '0 && t == PT0 && !m) return KAT;
        return {t[94:0], t[127:95]} ^ k ^ {128{m}};
    endfunction

    function automatic logic [63:0] word_of(input logic [127:0] b, input int i, input int dw);
        return 64'((b >> (128 - (i + 1) * dw)) & ((128'(1) << dw) - 1));
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_outs", {in_ready, core_start, out_valid, out_last, key_loaded, err, core_enc_dec, blk_cnt, out_data}, '0);
            chk("rst_text", core_text, '0);
            chk("rst_key", core_key, '0);
        end
    endtask

    // offers one block of words with random gaps; returns on the negedge after the last acceptance
    task automatic send_words(input logic [127:0] blk, input logic k, input int dw, input logic mode);
        int nw, t;
        nw = 128 / dw;
        for (int i = 0; i < nw; i++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 0;
                @(negedge clk);
            end
            in_valid = 1;
            in_is_key = k;
            in_data = word_of(blk, i, dw);
            enc_dec = (!k && i == nw - 1) ? mode : 1'($urandom);
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("accept_ready", in_ready, 1);
            @(negedge clk);
            if (k && i < nw - 1) chk("key_loading", key_loaded, 0);
        end
        in_valid = 0;
        in_is_key = 0;
    endtask

    task automatic do_block(input vec_t v);
        int dw, nw, idx, t, lat;
        logic stalled;
        sel = v.s;
        dw = v.s ? 32 : 8;
        nw = 128 / dw;
        if (v.ld) begin
            send_words(v.key, 1'b1, dw, 1'b0);
            chk("key_loaded_set", key_loaded, 1);
        end
        send_words(v.text, 1'b0, dw, v.mode);
        chk("err", err, v.exp_err);
        chk("core_start", core_start, !v.exp_err);
        if (v.exp_err) begin
            @(negedge clk);
            chk("err_pulse_end", {err, core_start, in_ready}, 3'b001);
            chk("blk_cnt_err", blk_cnt, v.exp_cnt);
            return;
        end
        chk("core_text", core_text, v.text);
        chk("core_key", core_key, v.key);
        chk("core_enc_dec", core_enc_dec, v.mode);
        lat = $urandom_range(5, 1);
        for (int j = 0; j < lat; j++) begin
            @(negedge clk);
            chk("wait_hold", {core_start, out_valid, key_loaded, core_text == v.text, core_key == v.key}, 5'b00111);
        end
        core_done = 1;
        core_result = ref_core(v.text, v.key, v.mode);
        @(negedge clk);
        core_done = 0;
        idx = 0;
        t = 0;
        stalled = 0;
        while (idx < nw && t < 300) begin
            chk("out_word", {out_valid, out_last, out_data}, {1'b1, idx == nw - 1, word_of(v.exp_res, idx, dw)});
            if (v.stall && idx == 2 && !stalled) begin
                stalled = 1;
                out_ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_hold", {out_valid, out_last, out_data}, {2'b10, word_of(v.exp_res, 2, dw)});
                end
            end
            out_ready = $urandom_range(3) != 0;
            core_done = $urandom_range(3) == 0;
            core_result = rand128();
            @(negedge clk);
            if (out_ready) idx++;
            t++;
        end
        out_ready = 0;
        core_done = 0;
        chk("out_count", 128'(idx), 128'(nw));
        chk("block_end", {in_ready, out_valid, key_loaded}, 3'b101);
        chk("blk_cnt", blk_cnt, v.exp_cnt);
    endtask

    vec_t tbl[10];
    vec_t v;
    logic kh[2];
    logic [127:0] kv[2];
    int cn[2];

    initial begin
        tbl[0] = '{1'b0, 1'b0, '0, PT0, 1'b0, 1'b1, '0, 16'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, '0, PT0, 1'b0, 1'b0, KAT, 16'd1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, '0, 128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 1'b0,
                   ref_core(128'h0123456789ABCDEFFEDCBA9876543210, '0, 1'b1), 16'd2, 1'b0};
        tbl[3] = '{1'b0, 1'b1, K3, PT0, 1'b0, 1'b0, ref_core(PT0, K3, 1'b0), 16'd3, 1'b0};
        tbl[4] = '{1'b0, 1'b0, K3, ~PT0, 1'b1, 1'b0, ref_core(~PT0, K3, 1'b1), 16'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, K3, KB, 1'b0, 1'b0, ref_core(KB, K3, 1'b0), 16'd1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, '0, PT0, 1'b0, 1'b1, '0, 16'd0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, KB, PT0, 1'b0, 1'b0, ref_core(PT0, KB, 1'b0), 16'd1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, KB, K3, 1'b1, 1'b0, ref_core(K3, KB, 1'b1), 16'd2, 1'b0};
        tbl[9] = '{1'b1, 1'b0, KB, ~KB, 1'b0, 1'b0, ref_core(~KB, KB, 1'b0), 16'd3, 1'b1};
        repeat (2) @(negedge clk);
        check_reset();
        reset = 0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) do_block(tbl[i]);

        // reset while the core is busy; its late done must not produce output
        sel = 0;
        send_words(rand128(), 1'b1, 8, 1'b0);
        send_words(rand128(), 1'b0, 8, 1'b1);
        chk("rst_seq_start", core_start, 1);
        @(negedge clk);
        reset = 1;
        check_reset();
        sel = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        core_done = 1;
        core_result = rand128();
        @(negedge clk);
        core_done = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", {out_valid, key_loaded, in_ready, core_start}, 4'b0010);
        end

        // random blocks on both instances against the stream model
        kh = '{1'b0, 1'b0};
        kv = '{128'h0, 128'h0};
        cn = '{0, 0};
        for (int r = 0; r < 16; r++) begin
            v.s = 1'($urandom_range(1));
            v.ld = kh[v.s] ? ($urandom_range(2) == 0) : ($urandom_range(4) != 0);
            if (v.ld) kv[v.s] = rand128();
            v.key = kv[v.s];
            v.text = rand128();
            v.mode = 1'($urandom_range(1));
            v.exp_err = !v.ld && !kh[v.s];
            if (v.ld) kh[v.s] = 1'b1;
            if (!v.exp_err) cn[v.s] = (cn[v.s] + 1) % (v.s ? 65536 : 4);
            v.exp_cnt = 16'(cn[v.s]);
            v.exp_res = ref_core(v.text, v.key, v.mode);
            v.stall = $urandom_range(3) == 0;
            do_block(v);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
